// File: rtl/pc_fetch_ctrl.sv
// Y86-64 program counter and fetch sequencer: issues one instruction-memory read
// per instruction, holds the window for decode and loads the next PC on commit.
module pc_fetch_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'h0,
  parameter int unsigned INSTR_W      = 80,
  parameter logic [31:0] RETIRED_INIT = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  output logic               imem_req_o,
  output logic [63:0]        imem_addr_o,
  input  logic               imem_ready_i,
  input  logic               imem_rsp_valid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               imem_err_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [63:0]        pc_o,
  input  logic               commit_i,
  input  logic [63:0]        next_pc_i,
  output logic               halted_o,
  output logic               err_o,
  output logic [31:0]        retired_cnt_o
);

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 32;
  localparam logic [3:0]  IHALT     = 4'h0;
  localparam logic [3:0]  ICODE_MAX = 4'hB;

  typedef enum logic [2:0] {
    S_REQ  = 3'd0,
    S_WAIT = 3'd1,
    S_HOLD = 3'd2,
    S_HALT = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic                 req, req_nxt;
  logic                 valid, valid_nxt;
  logic                 halted, halted_nxt;
  logic                 err, err_nxt;
  logic [XLEN-1:0]      pc, pc_nxt;
  logic [INSTR_W-1:0]   instr, instr_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [3:0]           icode;

  assign icode = instr[7:4];

  // State and output registers; flag outputs are pre-decoded from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= S_REQ;
      req    <= 1'b0;
      valid  <= 1'b0;
      halted <= 1'b0;
      err    <= 1'b0;
      pc     <= RESET_PC;
      instr  <= '0;
      cnt    <= RETIRED_INIT;
    end else begin
      state  <= state_nxt;
      req    <= req_nxt;
      valid  <= valid_nxt;
      halted <= halted_nxt;
      err    <= err_nxt;
      pc     <= pc_nxt;
      instr  <= instr_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Next-state and next-register logic
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    instr_nxt = instr;
    cnt_nxt   = cnt;

    unique case (state)
      S_REQ: begin
        // req is low for the first cycle out of reset, so no accept then
        if (req && imem_ready_i) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid_i) begin
          if (imem_err_i) begin
            state_nxt = S_ERR;
          end else begin
            instr_nxt = imem_rdata_i;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (commit_i) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (icode == IHALT) begin
            state_nxt = S_HALT;
          end else if (icode > ICODE_MAX) begin
            state_nxt = S_ERR;
          end else begin
            pc_nxt    = next_pc_i;
            state_nxt = S_REQ;
          end
        end
      end
      S_HALT: state_nxt = S_HALT;
      S_ERR:  state_nxt = S_ERR;
      default: state_nxt = S_ERR;
    endcase

    req_nxt    = (state_nxt == S_REQ);
    valid_nxt  = (state_nxt == S_HOLD);
    halted_nxt = (state_nxt == S_HALT);
    err_nxt    = (state_nxt == S_ERR);
  end

  assign imem_req_o    = req;
  assign imem_addr_o   = pc;
  assign instr_valid_o = valid;
  assign instr_o       = instr;
  assign pc_o          = pc;
  assign halted_o      = halted;
  assign err_o         = err;
  assign retired_cnt_o = cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized bench for pc_fetch_ctrl: memory responder, commit driver and a
// transaction-level reference model feeding a scoreboard of fetches and windows.
module tb_pc_fetch_ctrl;

  localparam int unsigned INSTR_W   = 80;
  localparam logic [63:0] RESET_PC  = 64'h100;
  localparam logic [31:0] CNT2_INIT = 32'hFFFF_FFFF;

  logic               clk = 1'b0;
  logic               rst_i;
  logic               imem_ready_i, imem_rsp_valid_i, imem_err_i, commit_i;
  logic [INSTR_W-1:0] imem_rdata_i;
  logic [63:0]        next_pc_i;

  logic               req_a, valid_a, halted_a, err_a;
  logic [63:0]        addr_a, pc_a;
  logic [INSTR_W-1:0] instr_a;
  logic [31:0]        cnt_a;
  logic               req_b, valid_b, halted_b, err_b;
  logic [63:0]        addr_b, pc_b;
  logic [INSTR_W-1:0] instr_b;
  logic [31:0]        cnt_b;

  always #5 clk = ~clk;

  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .INSTR_W(INSTR_W)) dut_a (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(req_a), .imem_addr_o(addr_a), .imem_ready_i(imem_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .instr_valid_o(valid_a), .instr_o(instr_a), .pc_o(pc_a),
    .commit_i(commit_i), .next_pc_i(next_pc_i),
    .halted_o(halted_a), .err_o(err_a), .retired_cnt_o(cnt_a)
  );

  // Second instance starts its counter at all-ones to exercise the wrap
  pc_fetch_ctrl #(.RESET_PC(RESET_PC), .INSTR_W(INSTR_W), .RETIRED_INIT(CNT2_INIT)) dut_b (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(req_b), .imem_addr_o(addr_b), .imem_ready_i(imem_ready_i),
    .imem_rsp_valid_i(imem_rsp_valid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .instr_valid_o(valid_b), .instr_o(instr_b), .pc_o(pc_b),
    .commit_i(commit_i), .next_pc_i(next_pc_i),
    .halted_o(halted_b), .err_o(err_b), .retired_cnt_o(cnt_b)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_fetch  = 0;
  int          ready_pct, commit_pct, err_pct, icode_mode;
  bit          npc_fixed;
  logic [63:0] fixed_npc;

  task automatic chk(input string name, input logic [INSTR_W-1:0] act, input logic [INSTR_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: one outstanding read, response 1..3 cycles after accept
  initial begin : mem_proc
    bit acc, in_rst, pend;
    int dly, r;
    logic [3:0]         ic;
    logic [INSTR_W-1:0] raw;
    pend = 0; dly = 0;
    imem_ready_i = 0; imem_rsp_valid_i = 0; imem_err_i = 0; imem_rdata_i = '0;
    forever begin
      @(negedge clk);
      acc    = req_a && imem_ready_i && !rst_i;
      in_rst = rst_i;
      @(posedge clk); #1;
      imem_rsp_valid_i = 0;
      imem_err_i       = 0;
      if (in_rst) pend = 0;
      else if (acc) begin
        pend = 1;
        dly  = int'($urandom_range(0, 2));
      end
      if (pend) begin
        if (dly == 0) begin
          pend = 0;
          raw  = 80'({$urandom(), $urandom(), $urandom()});
          r    = int'($urandom_range(0, 99));
          case (icode_mode)
            1: ic = 4'h1;
            2: ic = 4'h0;
            3: ic = 4'($urandom_range(12, 15));
            default: begin
              if (r < 6)       ic = 4'h0;
              else if (r < 12) ic = 4'($urandom_range(12, 15));
              else             ic = 4'($urandom_range(1, 11));
            end
          endcase
          raw[7:4] = ic;
          imem_rdata_i     = raw;
          imem_rsp_valid_i = 1;
          imem_err_i       = (int'($urandom_range(0, 99)) < err_pct);
        end else begin
          dly--;
        end
      end
      imem_ready_i = (int'($urandom_range(0, 99)) < ready_pct);
    end
  end

  // Reference model: instruction-level view of fetch, hold and retirement
  typedef enum int {P_FETCH, P_WAIT, P_HOLD, P_HALT, P_ERR} phase_e;
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [63:0]        pc;
  } fetch_t;

  phase_e             ph;
  logic [63:0]        m_pc;
  logic [31:0]        m_cnt, m_cnt2;
  logic [INSTR_W-1:0] m_instr;
  int                 age;
  bit                 prev_valid;
  logic [63:0]        addr_q[$];
  fetch_t             instr_q[$];

  task automatic check_dut(input string t, input logic req, input logic [63:0] addr,
                           input logic [INSTR_W-1:0] instr, input logic [63:0] pc,
                           input logic valid, input logic halted, input logic err,
                           input logic [31:0] cnt, input logic [31:0] exp_cnt);
    chk({t, ".instr_valid"}, 80'(valid), 80'(ph == P_HOLD));
    chk({t, ".halted"}, 80'(halted), 80'(ph == P_HALT));
    chk({t, ".err"}, 80'(err), 80'(ph == P_ERR));
    chk({t, ".pc"}, 80'(pc), 80'(m_pc));
    chk({t, ".retired_cnt"}, 80'(cnt), 80'(exp_cnt));
    chk({t, ".instr"}, instr, m_instr);
    if (ph != P_FETCH)  chk({t, ".req_idle"}, 80'(req), 80'(0));
    else if (age >= 1)  chk({t, ".req_fetch"}, 80'(req), 80'(1));
    if (req) chk({t, ".req_addr"}, 80'(addr), 80'(m_pc));
  endtask

  initial begin : monitor
    fetch_t f;
    logic [63:0] ea;
    ph = P_FETCH; m_pc = RESET_PC; m_cnt = 0; m_cnt2 = CNT2_INIT; m_instr = '0;
    age = 0; prev_valid = 0;
    addr_q.push_back(RESET_PC);
    forever begin
      @(negedge clk);
      check_dut("a", req_a, addr_a, instr_a, pc_a, valid_a, halted_a, err_a, cnt_a, m_cnt);
      check_dut("b", req_b, addr_b, instr_b, pc_b, valid_b, halted_b, err_b, cnt_b, m_cnt2);
      if (req_a && imem_ready_i && !rst_i) begin
        n_fetch++;
        if (addr_q.size() == 0) chk("fetch_unexpected", 80'(addr_a), 80'(64'hDEAD));
        else begin
          ea = addr_q.pop_front();
          chk("fetch_addr", 80'(addr_a), 80'(ea));
        end
      end
      if (valid_a && !prev_valid) begin
        if (instr_q.size() == 0) chk("window_unexpected", instr_a, 80'(1));
        else begin
          f = instr_q.pop_front();
          chk("window_instr", instr_a, f.instr);
          chk("window_pc", 80'(pc_a), 80'(f.pc));
        end
      end
      prev_valid = valid_a;

      if (rst_i) begin
        ph = P_FETCH; m_pc = RESET_PC; m_cnt = 0; m_cnt2 = CNT2_INIT; m_instr = '0; age = 0;
        addr_q.delete(); instr_q.delete();
        addr_q.push_back(RESET_PC);
      end else begin
        case (ph)
          P_FETCH: if (req_a && imem_ready_i) ph = P_WAIT; else age++;
          P_WAIT: if (imem_rsp_valid_i) begin
            if (imem_err_i) ph = P_ERR;
            else begin
              ph = P_HOLD;
              m_instr = imem_rdata_i;
              f.instr = imem_rdata_i;
              f.pc    = m_pc;
              instr_q.push_back(f);
            end
          end
          P_HOLD: if (commit_i) begin
            m_cnt  = m_cnt + 1;
            m_cnt2 = m_cnt2 + 1;
            if (m_instr[7:4] == 4'h0)     ph = P_HALT;
            else if (m_instr[7:4] > 4'hB) ph = P_ERR;
            else begin
              m_pc = next_pc_i;
              addr_q.push_back(next_pc_i);
              ph  = P_FETCH;
              age = 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic step(input bit rst);
    @(posedge clk); #1;
    rst_i     = rst;
    commit_i  = (int'($urandom_range(0, 99)) < commit_pct);
    next_pc_i = npc_fixed ? fixed_npc : {$urandom(), $urandom()};
  endtask

  initial begin : driver
    rst_i = 1; commit_i = 0; next_pc_i = '0;
    ready_pct = 100; commit_pct = 100; err_pct = 0; icode_mode = 1;
    npc_fixed = 1; fixed_npc = 64'h101;
    repeat (2) step(1);
    repeat (12) step(0);
    // memory not ready: request must hold steady
    ready_pct = 0;   repeat (6) step(0);
    ready_pct = 100; repeat (10) step(0);
    // HALT retires
    icode_mode = 2; fixed_npc = 64'h0; repeat (12) step(0);
    // memory error response
    icode_mode = 1; err_pct = 100; step(1); repeat (10) step(0);
    // invalid icode committed
    err_pct = 0; icode_mode = 3; step(1); repeat (10) step(0);
    // reset during WAIT and during HOLD
    icode_mode = 1; commit_pct = 0; step(1); repeat (3) step(0);
    step(1); repeat (8) step(0); step(1); repeat (6) step(0);
    // randomized traffic
    npc_fixed = 0; icode_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        ready_pct  = int'($urandom_range(30, 100));
        commit_pct = int'($urandom_range(10, 70));
        err_pct    = int'($urandom_range(0, 5));
      end
      if (halted_a || err_a) step(int'($urandom_range(0, 99)) < 20);
      else                   step(int'($urandom_range(0, 999)) < 8);
    end
    step(0); step(0);
    @(negedge clk); #1;
    chk("fetch_liveness", 80'(n_fetch >= 100), 80'(1));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
